// File: rtl/intc_pkg.sv
// Shared types and constants for the per-CPU interrupt selector.
// Fixed levels for the two special sources sit above any normal 4-bit level.
package intc_pkg;

  localparam logic [4:0] LVL_ERR = 5'd31;
  localparam logic [4:0] LVL_NMI = 5'd16;

  typedef logic [3:0] lvl4_t;

  typedef struct packed {
    logic       req;
    logic [4:0] level;
    logic [7:0] vec;
  } sel_t;

  // Vector numbers wrap modulo 256 by design.
  function automatic logic [7:0] vec_of(input logic [7:0] base, input int unsigned k);
    logic [31:0] kk;
    kk = k;
    return base + kk[7:0];
  endfunction

endpackage

// File: rtl/intc_sel_one_if.sv
// Selector <-> CPU interface link: registered request out, acknowledge strobes back.
// The selector is the master (it raises requests); the CPU interface stage is the slave.
interface intc_sel_one_if #(parameter int N = 32);
  logic         sl_req_o;
  logic [4:0]   sl_level_o;
  logic [7:0]   sl_vec_o;
  logic [N-1:0] cp_intack_i;
  logic         cp_intack_nmi_i;
  logic         cp_intack_err_i;
  logic         cp_intack_all_i;

  modport master (
    output sl_req_o, sl_level_o, sl_vec_o,
    input  cp_intack_i, cp_intack_nmi_i, cp_intack_err_i, cp_intack_all_i
  );

  modport slave (
    input  sl_req_o, sl_level_o, sl_vec_o,
    output cp_intack_i, cp_intack_nmi_i, cp_intack_err_i, cp_intack_all_i
  );
endinterface

// File: rtl/intc_prio_tree.sv
// Combinational log2(N)-deep max-level tree; on equal levels the lower index wins.
module intc_prio_tree
  import intc_pkg::*;
#(
  parameter int N  = 32,
  localparam int LV = (N > 1) ? $clog2(N) : 1,
  localparam int P  = 1 << LV
) (
  input  logic [N-1:0]       elig,
  input  logic [N-1:0][3:0]  lvl,
  output logic               valid,
  output lvl4_t              level,
  output logic [LV-1:0]      index
);

  logic          v [LV+1][P];
  lvl4_t         l [LV+1][P];
  logic [LV-1:0] x [LV+1][P];

  always_comb begin
    for (int s = 0; s <= LV; s++) begin
      for (int i = 0; i < P; i++) begin
        v[s][i] = 1'b0;
        l[s][i] = '0;
        x[s][i] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      v[0][i] = elig[i];
      l[0][i] = lvl[i];
      x[0][i] = LV'(i);
    end
    // Left child always holds the lower indices, so it keeps ties.
    for (int s = 0; s < LV; s++) begin
      for (int i = 0; i < (P >> (s + 1)); i++) begin
        if (v[s][2*i+1] && (!v[s][2*i] || (l[s][2*i+1] > l[s][2*i]))) begin
          v[s+1][i] = 1'b1;
          l[s+1][i] = l[s][2*i+1];
          x[s+1][i] = x[s][2*i+1];
        end else begin
          v[s+1][i] = v[s][2*i];
          l[s+1][i] = l[s][2*i];
          x[s+1][i] = x[s][2*i];
        end
      end
    end
  end

  assign valid = v[LV][0];
  assign level = l[LV][0];
  assign index = x[LV][0];

endmodule

// File: rtl/intc_sel_one.sv
// Per-CPU interrupt selector: latches sources into pending flags, arbitrates by level
// (err > NMI > normal) and presents one registered request to the CPU interface.
module intc_sel_one
  import intc_pkg::*;
#(
  parameter int         REG_NUM  = 1,
  parameter logic [7:0] VEC_BASE = 8'h40,
  parameter logic [7:0] NMI_VEC  = 8'h0B,
  parameter logic [7:0] ERR_VEC  = 8'h09,
  localparam int        N        = REG_NUM * 32,
  localparam int        IW       = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        irq_i,
  input  logic [N-1:0]        irq_edge_i,
  input  logic [N-1:0]        irq_en_i,
  input  logic [N-1:0][3:0]   irq_lvl_i,
  input  logic                nmi_i,
  input  logic                err_i,
  intc_sel_one_if.master      sl,
  output logic [N-1:0]        pend_o
);

  logic [N-1:0]  irq_q;
  logic [N-1:0]  pend;
  logic          nmi_q;
  logic          nmi_flag;
  logic          err_flag;
  logic [N-1:0]  elig;
  logic          t_valid;
  lvl4_t         t_level;
  logic [IW-1:0] t_idx;
  sel_t          sel;
  sel_t          sl_q;

  // Set terms are OR-ed after the clear so a same-cycle set always survives an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q    <= '0;
      pend     <= '0;
      nmi_q    <= 1'b0;
      nmi_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      irq_q    <= irq_i;
      pend     <= (irq_edge_i & ((irq_i & ~irq_q) | (pend & ~sl.cp_intack_i)))
                | (~irq_edge_i & irq_i);
      nmi_q    <= nmi_i;
      nmi_flag <= (nmi_i & ~nmi_q) | (nmi_flag & ~sl.cp_intack_nmi_i);
      err_flag <= err_i | (err_flag & ~sl.cp_intack_err_i);
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      elig[k] = pend[k] & irq_en_i[k] & (irq_lvl_i[k] != 4'd0);
    end
  end

  intc_prio_tree #(.N(N)) u_prio_tree (
    .elig  (elig),
    .lvl   (irq_lvl_i),
    .valid (t_valid),
    .level (t_level),
    .index (t_idx)
  );

  always_comb begin
    sel = '0;
    if (err_flag) begin
      sel.req   = 1'b1;
      sel.level = LVL_ERR;
      sel.vec   = ERR_VEC;
    end else if (nmi_flag) begin
      sel.req   = 1'b1;
      sel.level = LVL_NMI;
      sel.vec   = NMI_VEC;
    end else if (t_valid) begin
      sel.req   = 1'b1;
      sel.level = {1'b0, t_level};
      sel.vec   = vec_of(VEC_BASE, 32'(t_idx));
    end
  end

  // An ack blanks one cycle so the next selection sees the cleared pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_q <= '0;
    end else if (sl.cp_intack_all_i) begin
      sl_q <= '0;
    end else begin
      sl_q <= sel;
    end
  end

  assign sl.sl_req_o   = sl_q.req;
  assign sl.sl_level_o = sl_q.level;
  assign sl.sl_vec_o   = sl_q.vec;
  assign pend_o        = pend;

endmodule

// File: tb/tb_intc_sel_one.sv
// Directed bench for intc_sel_one with hand-computed expected request/level/vector values.
module tb_intc_sel_one;

  localparam int N = 32;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      irq_i;
  logic [N-1:0]      irq_edge_i;
  logic [N-1:0]      irq_en_i;
  logic [N-1:0][3:0] irq_lvl_i;
  logic              nmi_i;
  logic              err_i;
  logic [N-1:0]      pend_o;

  int errors = 0;
  int checks = 0;

  intc_sel_one_if #(.N(N)) sl_if ();

  intc_sel_one #(.REG_NUM(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_i      (irq_i),
    .irq_edge_i (irq_edge_i),
    .irq_en_i   (irq_en_i),
    .irq_lvl_i  (irq_lvl_i),
    .nmi_i      (nmi_i),
    .err_i      (err_i),
    .sl         (sl_if.master),
    .pend_o     (pend_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_normal(input int k);
    sl_if.cp_intack_i     = '0;
    sl_if.cp_intack_i[k]  = 1'b1;
    sl_if.cp_intack_all_i = 1'b1;
    tick();
    sl_if.cp_intack_i     = '0;
    sl_if.cp_intack_all_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    irq_i = '0; irq_edge_i = '1; irq_en_i = '1; irq_lvl_i = '0;
    nmi_i = 1'b0; err_i = 1'b0;
    sl_if.cp_intack_i = '0; sl_if.cp_intack_nmi_i = 1'b0;
    sl_if.cp_intack_err_i = 1'b0; sl_if.cp_intack_all_i = 1'b0;
    #3;
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== 14'h0) begin
      errors++; $display("FAIL reset_sl got=%h want=0", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o});
    end
    checks++;
    if (pend_o !== '0) begin errors++; $display("FAIL reset_pend got=%h want=0", pend_o); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_edge_single();
    irq_lvl_i[5] = 4'd3;
    irq_i[5] = 1'b1;
    tick();
    irq_i[5] = 1'b0;
    checks++;
    if ({pend_o[5], sl_if.sl_req_o} !== 2'b10) begin
      errors++; $display("FAIL edge_latency got pend/req=%b want=10", {pend_o[5], sl_if.sl_req_o});
    end
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd3, 8'h45}) begin
      errors++; $display("FAIL edge_present got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd3, 8'h45});
    end
    ack_normal(5);
    checks++;
    if (sl_if.sl_req_o !== 1'b0) begin errors++; $display("FAIL edge_ack_blank got=%b want=0", sl_if.sl_req_o); end
    tick();
    tick();
    checks++;
    if ({sl_if.sl_req_o, pend_o[5]} !== 2'b00) begin
      errors++; $display("FAIL edge_stay_clear got req/pend=%b want=00", {sl_if.sl_req_o, pend_o[5]});
    end
  endtask

  task automatic test_priority();
    irq_lvl_i[2] = 4'd7; irq_lvl_i[9] = 4'd7; irq_lvl_i[20] = 4'd4;
    irq_i[2] = 1'b1; irq_i[9] = 1'b1; irq_i[20] = 1'b1;
    tick();
    irq_i = '0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd7, 8'h42}) begin
      errors++; $display("FAIL prio_first got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd7, 8'h42});
    end
    ack_normal(2);
    checks++;
    if (sl_if.sl_req_o !== 1'b0) begin errors++; $display("FAIL prio_blank got=%b want=0", sl_if.sl_req_o); end
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd7, 8'h49}) begin
      errors++; $display("FAIL prio_second got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd7, 8'h49});
    end
    ack_normal(9);
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd4, 8'h54}) begin
      errors++; $display("FAIL prio_third got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd4, 8'h54});
    end
    ack_normal(20);
    tick();
    checks++;
    if (sl_if.sl_req_o !== 1'b0) begin errors++; $display("FAIL prio_drained got=%b want=0", sl_if.sl_req_o); end
  endtask

  task automatic test_nmi_err();
    irq_lvl_i[2] = 4'd15;
    irq_i[2] = 1'b1;
    tick();
    irq_i[2] = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd15, 8'h42}) begin
      errors++; $display("FAIL nmi_pre got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd15, 8'h42});
    end
    nmi_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd16, 8'h0B}) begin
      errors++; $display("FAIL nmi_present got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd16, 8'h0B});
    end
    err_i = 1'b1;
    tick();
    err_i = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd31, 8'h09}) begin
      errors++; $display("FAIL err_present got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd31, 8'h09});
    end
    sl_if.cp_intack_err_i = 1'b1; sl_if.cp_intack_all_i = 1'b1;
    tick();
    sl_if.cp_intack_err_i = 1'b0; sl_if.cp_intack_all_i = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd16, 8'h0B}) begin
      errors++; $display("FAIL nmi_after_err got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd16, 8'h0B});
    end
    sl_if.cp_intack_nmi_i = 1'b1; sl_if.cp_intack_all_i = 1'b1;
    tick();
    sl_if.cp_intack_nmi_i = 1'b0; sl_if.cp_intack_all_i = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd15, 8'h42}) begin
      errors++; $display("FAIL nmi_src_return got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd15, 8'h42});
    end
    nmi_i = 1'b0;
    ack_normal(2);
    tick();
  endtask

  task automatic test_level_mode();
    irq_edge_i[7] = 1'b0;
    irq_lvl_i[7]  = 4'd5;
    irq_i[7] = 1'b1;
    tick();
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd5, 8'h47}) begin
      errors++; $display("FAIL lvl_present got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd5, 8'h47});
    end
    ack_normal(7);
    checks++;
    if ({sl_if.sl_req_o, pend_o[7]} !== 2'b01) begin
      errors++; $display("FAIL lvl_ack got req/pend=%b want=01", {sl_if.sl_req_o, pend_o[7]});
    end
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_vec_o} !== {1'b1, 8'h47}) begin
      errors++; $display("FAIL lvl_represent got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_vec_o}, {1'b1, 8'h47});
    end
    irq_i[7] = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, pend_o[7]} !== 2'b10) begin
      errors++; $display("FAIL lvl_drop_pend got req/pend=%b want=10", {sl_if.sl_req_o, pend_o[7]});
    end
    tick();
    checks++;
    if (sl_if.sl_req_o !== 1'b0) begin errors++; $display("FAIL lvl_drop_req got=%b want=0", sl_if.sl_req_o); end
    irq_edge_i[7] = 1'b1;
  endtask

  task automatic test_set_wins_and_mask();
    irq_lvl_i[3] = 4'd6;
    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== {1'b1, 5'd6, 8'h43}) begin
      errors++; $display("FAIL sw_present got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o}, {1'b1, 5'd6, 8'h43});
    end
    irq_en_i[3] = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, pend_o[3]} !== 2'b01) begin
      errors++; $display("FAIL disable_withdraw got req/pend=%b want=01", {sl_if.sl_req_o, pend_o[3]});
    end
    irq_en_i[3] = 1'b1;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_vec_o} !== {1'b1, 8'h43}) begin
      errors++; $display("FAIL enable_return got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_vec_o}, {1'b1, 8'h43});
    end
    irq_i[3] = 1'b1;
    ack_normal(3);
    irq_i[3] = 1'b0;
    checks++;
    if ({sl_if.sl_req_o, pend_o[3]} !== 2'b01) begin
      errors++; $display("FAIL set_wins got req/pend=%b want=01", {sl_if.sl_req_o, pend_o[3]});
    end
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_vec_o} !== {1'b1, 8'h43}) begin
      errors++; $display("FAIL set_wins_rereq got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_vec_o}, {1'b1, 8'h43});
    end
    ack_normal(3);
    tick();
    irq_lvl_i[12] = 4'd0;
    irq_i[12] = 1'b1;
    tick();
    irq_i[12] = 1'b0;
    tick();
    tick();
    checks++;
    if ({sl_if.sl_req_o, pend_o[12]} !== 2'b01) begin
      errors++; $display("FAIL masked_lvl0 got req/pend=%b want=01", {sl_if.sl_req_o, pend_o[12]});
    end
  endtask

  task automatic test_reset_mid();
    irq_i[5] = 1'b1;
    tick();
    irq_i[5] = 1'b0;
    tick();
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_vec_o} !== {1'b1, 8'h45}) begin
      errors++; $display("FAIL rst_pre got=%h want=%h", {sl_if.sl_req_o, sl_if.sl_vec_o}, {1'b1, 8'h45});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o} !== 14'h0) begin
      errors++; $display("FAIL rst_async got=%h want=0", {sl_if.sl_req_o, sl_if.sl_level_o, sl_if.sl_vec_o});
    end
    checks++;
    if (pend_o !== '0) begin errors++; $display("FAIL rst_pend got=%h want=0", pend_o); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (sl_if.sl_req_o !== 1'b0) begin errors++; $display("FAIL rst_quiet got=%b want=0", sl_if.sl_req_o); end
  endtask

  initial begin
    test_reset();
    test_edge_single();
    test_priority();
    test_nmi_err();
    test_level_mode();
    test_set_wins_and_mask();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
